// File: rtl/mos6502_pkg.sv
// +--------------------------------------------------------------------------+
// | mos6502_pkg : shared types and constants for the 6502 program counter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mos6502_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FIXUP = 1'b1
  } pc_state_t;

  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

endpackage

`default_nettype wire

// File: rtl/pc_adder8.sv
// +--------------------------------------------------------------------------+
// | pc_adder8 : 8-bit adder with carry out for the branch low-byte sum       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       carry
);

  logic [8:0] sum9;

  assign sum9  = {1'b0, a} + {1'b0, b};
  assign sum   = sum9[7:0];
  assign carry = sum9[8];

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// +--------------------------------------------------------------------------+
// | pc_unit : 6502 program counter with jump, byte load, branch and inc      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_unit
  import mos6502_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        latch_lo,
  input  logic        jump,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic        branch,
  input  logic        inc,
  output logic [15:0] pc,
  output logic        busy,
  output logic        page_cross
);

  pc_state_t   state, state_next;
  logic [7:0]  lo_latch;
  logic        dir_neg, dir_neg_next;
  logic        page_cross_next;
  logic [15:0] pc_next;
  logic [7:0]  br_sum;
  logic        br_carry;

  pc_adder8 u_adder (
    .a     (pc[7:0]),
    .b     (data_in),
    .sum   (br_sum),
    .carry (br_carry)
  );

  always_comb begin
    pc_next         = pc;
    state_next      = state;
    dir_neg_next    = dir_neg;
    page_cross_next = 1'b0;
    if (state == FIXUP) begin
      pc_next[15:8]   = dir_neg ? (pc[15:8] - 8'd1) : (pc[15:8] + 8'd1);
      page_cross_next = 1'b1;
      state_next      = RUN;
    end else if (jump) begin
      pc_next = {data_in, lo_latch};
    end else if (load_lo || load_hi) begin
      if (load_lo) pc_next[7:0]  = data_in;
      if (load_hi) pc_next[15:8] = data_in;
    end else if (branch) begin
      pc_next[7:0] = br_sum;
      // Carry disagreeing with the offset sign means the high byte must move.
      if (br_carry ^ data_in[7]) begin
        dir_neg_next = data_in[7];
        state_next   = FIXUP;
      end
    end else if (inc) begin
      pc_next = pc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      lo_latch   <= 8'h00;
      state      <= RUN;
      dir_neg    <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      pc         <= pc_next;
      state      <= state_next;
      dir_neg    <= dir_neg_next;
      page_cross <= page_cross_next;
      if (latch_lo) lo_latch <= data_in;
    end
  end

  assign busy = (state == FIXUP);

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// +--------------------------------------------------------------------------+
// | tb_pc_unit : directed self-checking bench for pc_unit                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        latch_lo, jump, load_lo, load_hi, branch, inc;
  logic [15:0] pc;
  logic        busy, page_cross;

  int checks   = 0;
  int failures = 0;

  pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .latch_lo   (latch_lo),
    .jump       (jump),
    .load_lo    (load_lo),
    .load_hi    (load_hi),
    .branch     (branch),
    .inc        (inc),
    .pc         (pc),
    .busy       (busy),
    .page_cross (page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    latch_lo = 1'b0; jump = 1'b0; load_lo = 1'b0;
    load_hi  = 1'b0; branch = 1'b0; inc = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Set pc through two single-byte loads (RUN state required).
  task automatic set_pc(input logic [15:0] v);
    idle();
    load_hi = 1'b1; data_in = v[15:8]; step();
    load_hi = 1'b0; load_lo = 1'b1; data_in = v[7:0]; step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0; data_in = 8'h00; idle();
    step(); step();
    chk("reset_pc", pc, 16'hFFFC);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_pcross", {15'd0, page_cross}, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    inc = 1'b1; step(); idle();
    chk("inc_from_reset", pc, 16'hFFFD);

    // Mid-run async reset takes effect without a clock edge
    #1 rst_n = 1'b0; #1;
    chk("midrun_reset_pc", pc, 16'hFFFC);
    @(negedge clk); rst_n = 1'b1;

    latch_lo = 1'b1; data_in = 8'h34; step();
    latch_lo = 1'b0; jump = 1'b1; data_in = 8'h12; step(); idle();
    chk("jump_1234", pc, 16'h1234);

    // jump uses the old latch value while latch_lo loads a new one
    latch_lo = 1'b1; jump = 1'b1; data_in = 8'h56; step(); idle();
    chk("jump_old_latch", pc, 16'h5634);
    jump = 1'b1; data_in = 8'h00; step(); idle();
    chk("jump_new_latch", pc, 16'h0056);

    load_lo = 1'b1; load_hi = 1'b1; data_in = 8'hFF; step(); idle();
    chk("load_both", pc, 16'hFFFF);
    inc = 1'b1; step(); idle();
    chk("inc_wrap", pc, 16'h0000);
    inc = 1'b1; branch = 1'b1; data_in = 8'h05; step(); idle();
    chk("branch_over_inc", pc, 16'h0005);

    set_pc(16'h1210);
    branch = 1'b1; data_in = 8'h05; step(); idle();
    chk("br_fwd_nocross", pc, 16'h1215);
    chk("br_fwd_nocross_busy", {15'd0, busy}, 16'd0);
    set_pc(16'h1210);
    branch = 1'b1; data_in = 8'hF0; step(); idle();
    chk("br_back_nocross", pc, 16'h1200);
    chk("br_back_nocross_busy", {15'd0, busy}, 16'd0);

    set_pc(16'h12F0);
    branch = 1'b1; data_in = 8'h20; step(); idle();
    chk("fwd_cross_lo", pc, 16'h1210);
    chk("fwd_cross_busy", {15'd0, busy}, 16'd1);
    chk("fwd_cross_pc0", {15'd0, page_cross}, 16'd0);
    inc = 1'b1; step(); idle();
    chk("fwd_cross_fix", pc, 16'h1310);
    chk("fwd_cross_pc1", {15'd0, page_cross}, 16'd1);
    chk("fwd_cross_idle", {15'd0, busy}, 16'd0);
    step();
    chk("fwd_cross_inc_dropped", pc, 16'h1310);
    chk("fwd_cross_pulse_end", {15'd0, page_cross}, 16'd0);

    set_pc(16'h1205);
    branch = 1'b1; data_in = 8'hF0; step(); idle();
    chk("back_cross_lo", pc, 16'h12F5);
    chk("back_cross_busy", {15'd0, busy}, 16'd1);
    latch_lo = 1'b1; data_in = 8'hAB; step(); idle();
    chk("back_cross_fix", pc, 16'h11F5);
    chk("back_cross_pc1", {15'd0, page_cross}, 16'd1);
    jump = 1'b1; data_in = 8'h00; step(); idle();
    chk("latch_during_fixup", pc, 16'h00AB);

    set_pc(16'h0005);
    branch = 1'b1; data_in = 8'hF0; step(); idle();
    chk("back_wrap_lo", pc, 16'h00F5);
    step();
    chk("back_wrap_fix", pc, 16'hFFF5);

    set_pc(16'hFFF0);
    branch = 1'b1; data_in = 8'h20; step(); idle();
    chk("fwd_wrap_lo", pc, 16'hFF10);
    step();
    chk("fwd_wrap_fix", pc, 16'h0010);

    // Reset during FIXUP abandons the high-byte correction
    set_pc(16'h12F0);
    branch = 1'b1; data_in = 8'h20; step(); idle();
    chk("abort_busy_before", {15'd0, busy}, 16'd1);
    rst_n = 1'b0; #1;
    chk("abort_pc", pc, 16'hFFFC);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    step();
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("abort_no_fix", pc, 16'hFFFC);
    chk("abort_no_pulse", {15'd0, page_cross}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
